// File: rtl/spi_pkg.sv
// Shared constants for the SPI burst sequencer: byte width, FSM state encoding and
// bit positions inside err_flags.
package spi_pkg;

  localparam int SPI_BYTE_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_ISSUE = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_STORE = 3'd4;
  localparam logic [2:0] ST_FIN   = 3'd5;

  localparam int ERR_RX_UDF = 0;
  localparam int ERR_TX_OVF = 1;
  localparam int ERR_RX_OVF = 2;

endpackage

// File: rtl/spi_sync_fifo.sv
// Synchronous show-ahead FIFO: head visible combinationally, a push is visible one cycle later.
// No backpressure: a push on full (without a same-cycle pop) or a pop on empty is dropped.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en_i,
  input  logic [WIDTH-1:0]       wr_data_i,
  input  logic                   rd_en_i,
  output logic [WIDTH-1:0]       rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  // DEPTH is a power of two, so the level MSB is set only when completely full.
  assign full_o  = level_q[AW];
  assign do_pop  = rd_en_i & ~empty_o;
  assign do_push = wr_en_i & (~full_o | do_pop);

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o   = level_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Feeds spi_master one byte per transaction from a TX FIFO, storing replies in an RX FIFO.
// go->m_start 2 cycles, m_done->RX push 1 cycle; stalls in LOAD while TX is empty or master busy.
module spi_burst_sequencer
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        tx_wr_en,
  input  logic [SPI_BYTE_W-1:0]       tx_wr_data,
  output logic                        tx_full,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  input  logic                        rx_rd_en,
  output logic [SPI_BYTE_W-1:0]       rx_rd_data,
  output logic                        rx_empty,
  output logic [$clog2(FIFO_DEPTH):0] rx_level,
  input  logic [7:0]                  burst_len,
  input  logic                        go,
  input  logic                        abort,
  output logic                        seq_busy,
  output logic                        burst_done,
  output logic [2:0]                  err_flags,
  input  logic                        err_clr,
  output logic                        m_start,
  output logic [SPI_BYTE_W-1:0]       m_tx_data,
  input  logic                        m_ready,
  input  logic                        m_done,
  input  logic [SPI_BYTE_W-1:0]       m_rx_data
);

  logic [2:0]            state_q, state_d;
  logic [7:0]            remaining_q, remaining_d;
  logic                  abort_pend_q, abort_pend_d;
  logic [SPI_BYTE_W-1:0] m_tx_data_q, m_tx_data_d;
  logic [SPI_BYTE_W-1:0] rx_cap_q, rx_cap_d;
  logic [2:0]            err_q, err_d;

  logic                  tx_empty;
  logic                  tx_pop;
  logic [SPI_BYTE_W-1:0] tx_head;
  logic                  rx_push;
  logic                  rx_full;

  spi_sync_fifo #(
    .WIDTH (SPI_BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (tx_wr_en),
    .wr_data_i (tx_wr_data),
    .rd_en_i   (tx_pop),
    .rd_data_o (tx_head),
    .full_o    (tx_full),
    .empty_o   (tx_empty),
    .level_o   (tx_level)
  );

  spi_sync_fifo #(
    .WIDTH (SPI_BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en_i   (rx_push),
    .wr_data_i (rx_cap_q),
    .rd_en_i   (rx_rd_en),
    .rd_data_o (rx_rd_data),
    .full_o    (rx_full),
    .empty_o   (rx_empty),
    .level_o   (rx_level)
  );

  assign m_start    = (state_q == ST_ISSUE);
  assign tx_pop     = m_start;
  assign rx_push    = (state_q == ST_STORE);
  assign burst_done = (state_q == ST_FIN);
  assign seq_busy   = (state_q != ST_IDLE);
  assign m_tx_data  = m_tx_data_q;
  assign err_flags  = err_q;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    abort_pend_d = abort_pend_q;
    m_tx_data_d  = m_tx_data_q;
    rx_cap_d     = rx_cap_q;
    case (state_q)
      ST_IDLE: begin
        if (go) begin
          if (burst_len != '0) begin
            remaining_d = burst_len;
            state_d     = ST_LOAD;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_LOAD: begin
        if (abort) begin
          state_d = ST_FIN;
        end else if (!tx_empty && m_ready) begin
          // Latch the head on the way into ISSUE so it is already stable while m_start is high.
          m_tx_data_d = tx_head;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (abort) begin
          abort_pend_d = 1'b1;
        end
        if (m_done) begin
          rx_cap_d = m_rx_data;
          state_d  = ST_STORE;
        end
      end
      ST_STORE: begin
        remaining_d = remaining_q - 8'd1;
        if (remaining_q == 8'd1 || abort_pend_q || abort) begin
          state_d = ST_FIN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_FIN: begin
        abort_pend_d = 1'b0;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A new error in the same cycle as err_clr must survive the clear.
  always_comb begin
    err_d = err_clr ? 3'b000 : err_q;
    if (tx_wr_en && tx_full && !tx_pop) begin
      err_d[ERR_TX_OVF] = 1'b1;
    end
    if (rx_push && rx_full && !(rx_rd_en && !rx_empty)) begin
      err_d[ERR_RX_OVF] = 1'b1;
    end
    if (rx_rd_en && rx_empty) begin
      err_d[ERR_RX_UDF] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      abort_pend_q <= 1'b0;
      m_tx_data_q  <= '0;
      rx_cap_q     <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      abort_pend_q <= abort_pend_d;
      m_tx_data_q  <= m_tx_data_d;
      rx_cap_q     <= rx_cap_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Bench for spi_burst_sequencer with a behavioural loopback SPI master (MISO tied to MOSI).
module tb_spi_burst_sequencer;
  import spi_pkg::*;

  localparam int MDL_CYC = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_wr_en, rx_rd_en, go, abort, err_clr;
  logic [7:0] tx_wr_data, burst_len;
  logic       tx_full, rx_empty, seq_busy, burst_done, m_start, m_ready, m_done;
  logic [4:0] tx_level, rx_level;
  logic [7:0] rx_rd_data, m_tx_data, m_rx_data;
  logic [2:0] err_flags;

  logic       mdl_busy;
  logic [7:0] mdl_sh;
  int         mdl_cnt;

  int n_chk = 0;
  int n_err = 0;
  int n_start = 0;
  int n_done = 0;
  logic [7:0] expq [$];

  logic [7:0] t1_bytes [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
  logic [7:0] t2_bytes [3] = '{8'h11, 8'h22, 8'h33};

  spi_burst_sequencer #(.FIFO_DEPTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .tx_wr_en   (tx_wr_en),
    .tx_wr_data (tx_wr_data),
    .tx_full    (tx_full),
    .tx_level   (tx_level),
    .rx_rd_en   (rx_rd_en),
    .rx_rd_data (rx_rd_data),
    .rx_empty   (rx_empty),
    .rx_level   (rx_level),
    .burst_len  (burst_len),
    .go         (go),
    .abort      (abort),
    .seq_busy   (seq_busy),
    .burst_done (burst_done),
    .err_flags  (err_flags),
    .err_clr    (err_clr),
    .m_start    (m_start),
    .m_tx_data  (m_tx_data),
    .m_ready    (m_ready),
    .m_done     (m_done),
    .m_rx_data  (m_rx_data)
  );

  always #5 clk = ~clk;

  // Loopback master: one byte takes MDL_CYC cycles, returns the byte it was given.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mdl_busy  <= 1'b0;
      mdl_sh    <= 8'h00;
      mdl_cnt   <= 0;
      m_done    <= 1'b0;
      m_rx_data <= 8'h00;
    end else begin
      m_done <= 1'b0;
      if (m_start && !mdl_busy) begin
        mdl_busy <= 1'b1;
        mdl_sh   <= m_tx_data;
        mdl_cnt  <= MDL_CYC;
      end else if (mdl_busy) begin
        if (mdl_cnt == 1) begin
          mdl_busy  <= 1'b0;
          m_done    <= 1'b1;
          m_rx_data <= mdl_sh;
        end
        mdl_cnt <= mdl_cnt - 1;
      end
    end
  end
  assign m_ready = !mdl_busy && !m_done;

  always @(posedge clk) begin
    if (reset_n) begin
      if (m_start)    n_start <= n_start + 1;
      if (burst_done) n_done  <= n_done + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_wr_en   = 1'b1;
    tx_wr_data = b;
    tick();
    tx_wr_en   = 1'b0;
  endtask

  task automatic pulse_go(input logic [7:0] len);
    burst_len = len;
    go        = 1'b1;
    tick();
    go        = 1'b0;
  endtask

  task automatic pop_chk(input string tag);
    logic [7:0] e;
    e = 'x;
    if (expq.size() > 0) e = expq.pop_front();
    chk({tag, "_empty"}, rx_empty, 0);
    chk(tag, rx_rd_data, e);
    rx_rd_en = 1'b1;
    tick();
    rx_rd_en = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      seen = burst_done;
    end
    chk({tag, "_done_seen"}, seen, 1);
  endtask

  task automatic wait_starts(input string tag, input int target, input int budget);
    for (int i = 0; i < budget && n_start < target; i++) tick();
    chk({tag, "_start_seen"}, (n_start >= target), 1);
  endtask

  initial begin
    int s0, d0;
    logic [7:0] b;
    tx_wr_en = 0; tx_wr_data = 0; rx_rd_en = 0; go = 0; abort = 0; err_clr = 0; burst_len = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_level", rx_level, 0);
    chk("rst_tx_full", tx_full, 0);
    chk("rst_rx_empty", rx_empty, 1);
    chk("rst_m_start", m_start, 0);
    chk("rst_m_tx_data", m_tx_data, 0);
    chk("rst_busy", seq_busy, 0);
    chk("rst_burst_done", burst_done, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_rx_data", rx_rd_data, 0);
    reset_n = 1'b1;
    tick();

    // Basic 4-byte burst
    for (int i = 0; i < 4; i++) begin
      push_tx(t1_bytes[i]);
      expq.push_back(t1_bytes[i]);
    end
    chk("t1_tx_level", tx_level, 4);
    s0 = n_start; d0 = n_done;
    pulse_go(8'd4);
    chk("t1_busy", seq_busy, 1);
    chk("t1_start_n1", m_start, 0);
    tick();
    chk("t1_start_n2", m_start, 1);
    chk("t1_m_tx_data", m_tx_data, 8'hA5);
    wait_done("t1", 2000);
    tick();
    chk("t1_n_start", n_start - s0, 4);
    chk("t1_n_done", n_done - d0, 1);
    chk("t1_err", err_flags, 0);
    chk("t1_rx_level", rx_level, 4);
    chk("t1_tx_hold", m_tx_data, 8'h00);
    for (int i = 0; i < 4; i++) pop_chk("t1_rx");

    // Burst started on an empty TX FIFO; bytes trickle in
    s0 = n_start; d0 = n_done;
    pulse_go(8'd3);
    for (int i = 0; i < 3; i++) begin
      repeat (5) tick();
      chk("t2_stall_load", dut.state_q, ST_LOAD);
      chk("t2_starts", n_start - s0, i);
      chk("t2_no_early_done", n_done - d0, 0);
      push_tx(t2_bytes[i]);
      expq.push_back(t2_bytes[i]);
      if (i < 2) repeat (199) tick();
    end
    wait_done("t2", 400);
    tick();
    chk("t2_n_start", n_start - s0, 3);
    for (int i = 0; i < 3; i++) pop_chk("t2_rx");

    // TX overflow, err_clr vs new error, then drain 16 bytes through a full RX FIFO
    for (int i = 0; i < 16; i++) begin
      b = 8'h40 + 8'(i);
      push_tx(b);
      expq.push_back(b);
    end
    chk("t3_full", tx_full, 1);
    chk("t3_level16", tx_level, 16);
    chk("t3_err_pre", err_flags, 0);
    push_tx(8'hEE);
    chk("t3_level_after_drop", tx_level, 16);
    chk("t3_tx_ovf", err_flags, 3'b010);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t3_err_clr", err_flags, 0);
    err_clr = 1'b1; tx_wr_en = 1'b1; tx_wr_data = 8'hEF;
    tick();
    err_clr = 1'b0; tx_wr_en = 1'b0;
    chk("t3_err_wins", err_flags, 3'b010);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    pulse_go(8'd16);
    wait_done("t3", 3000);
    tick();
    chk("t3_rx_level", rx_level, 16);
    chk("t3_tx_level", tx_level, 0);
    chk("t3_err_none", err_flags, 0);
    for (int i = 0; i < 16; i++) pop_chk("t3_rx");

    // Abort during the second byte's WAIT
    for (int i = 0; i < 8; i++) begin
      b = 8'h80 + 8'(i);
      push_tx(b);
      if (i < 2) expq.push_back(b);
    end
    s0 = n_start;
    pulse_go(8'd8);
    wait_starts("t4", s0 + 2, 500);
    chk("t4_in_wait", dut.state_q, ST_WAIT);
    abort = 1'b1; tick(); abort = 1'b0;
    wait_done("t4", 300);
    tick();
    chk("t4_n_start", n_start - s0, 2);
    chk("t4_rx_level", rx_level, 2);
    chk("t4_tx_level", tx_level, 6);
    for (int i = 0; i < 2; i++) pop_chk("t4_rx");

    // Zero-length burst and RX underflow
    s0 = n_start; d0 = n_done;
    pulse_go(8'd0);
    chk("t5_done_n1", burst_done, 1);
    chk("t5_busy_n1", seq_busy, 1);
    tick();
    chk("t5_done_n2", burst_done, 0);
    chk("t5_idle", seq_busy, 0);
    repeat (3) tick();
    chk("t5_no_start", n_start - s0, 0);
    chk("t5_one_done", n_done - d0, 1);
    rx_rd_en = 1'b1; tick(); rx_rd_en = 1'b0;
    chk("t5_rx_udf", err_flags, 3'b001);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("t5_err_clr", err_flags, 0);

    // Asynchronous reset in the middle of a WAIT
    s0 = n_start;
    pulse_go(8'd1);
    wait_starts("t6", s0 + 1, 100);
    repeat (5) tick();
    chk("t6_in_wait", dut.state_q, ST_WAIT);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_busy", seq_busy, 0);
    chk("t6_m_start", m_start, 0);
    chk("t6_m_tx_data", m_tx_data, 0);
    chk("t6_tx_level", tx_level, 0);
    chk("t6_rx_level", rx_level, 0);
    chk("t6_rx_empty", rx_empty, 1);
    chk("t6_tx_full", tx_full, 0);
    chk("t6_done", burst_done, 0);
    chk("t6_err", err_flags, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    tick();
    push_tx(8'h5A);
    expq.push_back(8'h5A);
    pulse_go(8'd1);
    wait_done("t6", 300);
    tick();
    chk("t6_rx_level", rx_level, 1);
    pop_chk("t6_rx");
    chk("t6_rx_drained", rx_empty, 1);

    chk("sb_leftover", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
